muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit for the pipelined core. Consumes the two register-file read operands for a multiply or divide instruction, computes the result over multiple cycles, and drives the register-file write port (`reg_wr`/`waddr`/`wdata`) for one cycle when the result is ready. Its `busy` output stalls the front end while an operation is in flight.

---
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with a single-cycle register-file write pulse on completion.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            reg_wr,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata,
    output logic [1:0]      dbg_state
);

    // Handshake: start is accepted only while busy=0 (and flush=0); the result is valid
    // for exactly the one cycle done=1, and reg_wr qualifies the register-file write.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [63:0]     acc_q, acc_d;
    logic [31:0]     opb_q;
    logic [5:0]      cnt_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic            neg_q;
    logic            rneg_q;
    logic [4:0]      waddr_q;
    logic [XLEN-1:0] wdata_q;

    logic        launch;
    logic        a_signed, b_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        div_by_zero, div_ovf, special;

    // Launch-time operand decode
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (funct3[2]) begin
            a_signed = ~funct3[0];
            b_signed = ~funct3[0];
        end else begin
            a_signed = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
            b_signed = (funct3[1:0] == 2'b01);
        end
        a_neg       = a_signed & rs1_data[31];
        b_neg       = b_signed & rs2_data[31];
        a_mag       = a_neg ? (~rs1_data + 32'd1) : rs1_data;
        b_mag       = b_neg ? (~rs2_data + 32'd1) : rs2_data;
        div_by_zero = funct3[2] && (rs2_data == 32'd0);
        div_ovf     = funct3[2] && !funct3[0] &&
                      (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
        special     = div_by_zero || div_ovf;
        launch      = (state_q == S_IDLE) && start && !flush;
    end

    // acc_q holds {high, low}: product-high/multiplier for multiply,
    // remainder/quotient (dividend shifting out) for divide.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (f3_q[2]) begin
            if (div_diff[32]) begin
                acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
            end else begin
                acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
            end
        end else begin
            acc_d = {mul_sum, acc_q[31:1]};
        end
    end

    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] result;

    always_comb begin
        prod_fix = neg_q  ? (~acc_q + 64'd1) : acc_q;
        quot_fix = neg_q  ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix  = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        case (f3_q)
            3'b000:                 result = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: result = prod_fix[63:32];
            3'b100, 3'b101:         result = quot_fix;
            default:                result = rem_fix;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = special ? S_FIXUP : S_CALC;
                S_CALC:  if (cnt_q == 6'd31) state_d = S_FIXUP;
                S_FIXUP: state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE) && !flush;
        reg_wr    = done && (waddr_q != 5'd0);
        waddr     = waddr_q;
        wdata     = wdata_q;
        dbg_state = state_q;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= 64'd0;
            opb_q   <= 32'd0;
            cnt_q   <= 6'd0;
            f3_q    <= 3'd0;
            rd_q    <= 5'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= '0;
        end else if (launch) begin
            f3_q  <= funct3;
            rd_q  <= rd_addr;
            cnt_q <= 6'd0;
            if (div_by_zero) begin
                // Final values are stored directly, so sign correction is disabled.
                acc_q  <= {rs1_data, 32'hFFFF_FFFF};
                opb_q  <= 32'd0;
                neg_q  <= 1'b0;
                rneg_q <= 1'b0;
            end else if (div_ovf) begin
                acc_q  <= {32'd0, 32'h8000_0000};
                opb_q  <= 32'd0;
                neg_q  <= 1'b0;
                rneg_q <= 1'b0;
            end else begin
                acc_q  <= {32'd0, a_mag};
                opb_q  <= b_mag;
                neg_q  <= a_neg ^ b_neg;
                rneg_q <= a_neg;
            end
        end else if (state_q == S_CALC) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 6'd1;
        end else if ((state_q == S_FIXUP) && !flush) begin
            wdata_q <= result;
            waddr_q <= rd_q;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit: directed RV32M corner cases, flush/reset
// aborts and ignored starts, plus random ops checked against a plain-arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   funct3;
  logic [W-1:0] rs1_data;
  logic [W-1:0] rs2_data;
  logic [4:0]   rd_addr;
  logic         flush;
  logic         busy;
  logic         done;
  logic         reg_wr;
  logic [4:0]   waddr;
  logic [W-1:0] wdata;
  logic [1:0]   dbg_state;

  muldiv_unit #(.XLEN(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr), .flush(flush),
    .busy(busy), .done(done), .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [4:0]   rd_q[$];
  int           due_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: full-width integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 64'd0;
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        r = sa / sb;
        p = 64'(r);
        return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        r = sa % sb;
        p = 64'(r);
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && ((b == 32'd0) ||
                    (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // monitor: pops one expected result per done pulse
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    logic [4:0]   r;
    int           d;
    if (reset === 1'b0) begin
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: done=1 waddr=%0d wdata=0x%0h, required no completion",
                   waddr, wdata);
        end else begin
          e = exp_q.pop_front();
          r = rd_q.pop_front();
          d = due_q.pop_front();
          check("wdata", 64'(wdata), 64'(e));
          check("waddr", 64'(waddr), 64'(r));
          check("reg_wr", 64'(reg_wr), 64'(r != 5'd0));
          check("done_cycle", 64'(cyc), 64'(d));
        end
      end else if (reg_wr !== 1'b0) begin
        check("reg_wr_without_done", 64'(reg_wr), 64'd0);
      end
    end
  end

  // driver tasks (inputs change #1 after the rising edge)
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    rs1_data = $urandom;
    rs2_data = $urandom;
    funct3   = 3'($urandom_range(0, 7));
    rd_addr  = 5'($urandom_range(0, 31));
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit expect_result, input logic [31:0] e);
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    rd_addr  = rd;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
    if (expect_result) begin
      exp_q.push_back(e);
      rd_q.push_back(rd);
      due_q.push_back(cyc + (is_special(f, a, b) ? 1 : 33));
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
    end
    if (busy !== 1'b0) check("busy_timeout", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] rd, input logic [31:0] e);
    int n;
    issue(f, a, b, rd, 1'b1, e);
    wait_idle(n);
    check("busy_cycles", 64'(n), is_special(f, a, b) ? 64'd2 : 64'd34);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},   64'(busy),   64'd0);
    check({tag, "_done"},   64'(done),   64'd0);
    check({tag, "_reg_wr"}, 64'(reg_wr), 64'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;

    reset = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; rs1_data = '0; rs2_data = '0; rd_addr = 5'd0;
    tick(3);
    check_idle_outputs("reset");
    check("reset_waddr", 64'(waddr), 64'd0);
    check("reset_wdata", 64'(wdata), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    tick(1);

    // directed corner cases
    op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    op(3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000);
    op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE);
    op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF);
    op(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD);
    op(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFF);
    op(3'd5, 32'd100,        32'd7,         5'd6,  32'd14);
    op(3'd7, 32'd100,        32'd7,         5'd7,  32'd2);
    op(3'd4, 32'd5,          32'd0,         5'd8,  32'hFFFF_FFFF);
    op(3'd7, 32'd5,          32'd0,         5'd9,  32'd5);
    op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000);
    op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'd0);
    op(3'd0, 32'd3,          32'd4,         5'd0,  32'd12);

    // start during CALC is ignored
    issue(3'd5, 32'd100, 32'd7, 5'd3, 1'b1, 32'd14);
    tick(5);
    funct3 = 3'd0; rs1_data = 32'd123; rs2_data = 32'd456; rd_addr = 5'd9; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(n);
    check("busy_after_ignored_start", 64'(n), 64'd28);

    // flush at cycle 10 of a DIV, then an immediate new op
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0, 32'd0);
    tick(9);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check_idle_outputs("flush_calc");
    op(3'd5, 32'd100, 32'd7, 5'd12, 32'd14);

    // flush while in DONE suppresses the write
    issue(3'd4, 32'd5, 32'd0, 5'd6, 1'b0, 32'd0);
    tick(1);
    flush = 1'b1;
    @(negedge clk);
    check("flush_done_done", 64'(done), 64'd0);
    check("flush_done_reg_wr", 64'(reg_wr), 64'd0);
    tick(1);
    flush = 1'b0;
    check("flush_done_busy", 64'(busy), 64'd0);

    // flush beats start in the same cycle
    funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd_addr = 5'd1;
    start = 1'b1; flush = 1'b1;
    tick(1);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    tick(2);
    check("flush_start_no_launch", 64'(busy), 64'd0);

    // reset in the middle of a MUL clears everything
    issue(3'd0, 32'h1234, 32'h5678, 5'd7, 1'b0, 32'd0);
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_idle_outputs("reset_mid");
    check("reset_mid_waddr", 64'(waddr), 64'd0);
    check("reset_mid_wdata", 64'(wdata), 64'd0);
    tick(2);
    check("reset_mid_stays_idle", 64'(busy), 64'd0);

    // randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom_range(0, 31));
      op(f, a, b, rd, ref_model(f, a, b));
    end

    tick(5);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
